// File: rtl/rab_ar_sender_if.sv
// AR request channel toward the master port and the R error-beat channel toward
// the slave port of rab_ar_sender, grouped for use as a single port.
interface rab_ar_sender_if #(
  parameter int AXI_M_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH     = 8,
  parameter int AXI_USER_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH   = 64
) ();
  logic                        m_ar_valid_o;
  logic                        m_ar_ready_i;
  logic [AXI_M_ADDR_WIDTH-1:0] m_ar_addr_o;
  logic [AXI_ID_WIDTH-1:0]     m_ar_id_o;
  logic [7:0]                  m_ar_len_o;
  logic [AXI_USER_WIDTH-1:0]   m_ar_user_o;
  logic                        m_ar_coherent_o;
  logic                        s_r_valid_o;
  logic                        s_r_ready_i;
  logic [AXI_ID_WIDTH-1:0]     s_r_id_o;
  logic [AXI_DATA_WIDTH-1:0]   s_r_data_o;
  logic [1:0]                  s_r_resp_o;
  logic                        s_r_last_o;

  modport master (
    output m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_coherent_o,
    input  m_ar_ready_i,
    output s_r_valid_o, s_r_id_o, s_r_data_o, s_r_resp_o, s_r_last_o,
    input  s_r_ready_i
  );

  modport slave (
    input  m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_coherent_o,
    output m_ar_ready_i,
    input  s_r_valid_o, s_r_id_o, s_r_data_o, s_r_resp_o, s_r_last_o,
    output s_r_ready_i
  );
endinterface

// File: rtl/rab_ar_sender.sv
// Per-port AR-channel consumer of the RAB lookup decision: forwards accepted reads,
// answers dropped reads with len+1 SLVERR beats, and counts drops/misses.
module rab_ar_sender #(
  parameter int AXI_M_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH     = 8,
  parameter int AXI_USER_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        accept_i,
  input  logic                        drop_i,
  input  logic                        miss_i,
  input  logic [AXI_M_ADDR_WIDTH-1:0] out_addr_i,
  input  logic                        cache_coherent_i,
  input  logic [AXI_ID_WIDTH-1:0]     in_id_i,
  input  logic [7:0]                  in_len_i,
  input  logic [AXI_USER_WIDTH-1:0]   in_user_i,
  output logic                        sent_o,
  rab_ar_sender_if.master             bus,
  output logic                        err_busy_o,
  output logic [CNT_WIDTH-1:0]        drop_cnt_o,
  output logic [CNT_WIDTH-1:0]        miss_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic                        w_cap_drop;
  logic                        w_cap_acc;
  logic                        w_last;
  logic                        w_err_valid;
  logic [AXI_M_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [7:0]                  r_len;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_coh;
  logic [7:0]                  r_beat_cnt;
  logic [CNT_WIDTH-1:0]        r_drop_cnt;
  logic [CNT_WIDTH-1:0]        r_miss_cnt;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drop wins over accept if the lookup ever raises both.
  always_comb begin
    w_state_nxt = r_state;
    sent_o      = 1'b0;
    w_cap_drop  = 1'b0;
    w_cap_acc   = 1'b0;
    w_last      = (r_beat_cnt == 8'd0);
    case (r_state)
      S_IDLE: begin
        if (drop_i) begin
          w_cap_drop  = 1'b1;
          w_state_nxt = S_ERR;
        end else if (accept_i) begin
          w_cap_acc   = 1'b1;
          w_state_nxt = S_ADDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (bus.m_ar_ready_i) begin
          sent_o      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ERR: begin
        if (bus.s_r_ready_i && w_last) begin
          sent_o      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_addr <= '0;
      r_id   <= '0;
      r_len  <= 8'd0;
      r_user <= '0;
      r_coh  <= 1'b0;
    end else if (w_cap_acc) begin
      r_addr <= out_addr_i;
      r_id   <= in_id_i;
      r_len  <= in_len_i;
      r_user <= in_user_i;
      r_coh  <= cache_coherent_i;
    end else if (w_cap_drop) begin
      r_id   <= in_id_i;
      r_len  <= in_len_i;
    end
  end

  // Beat counter holds the number of error beats still owed after the current one.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_beat_cnt <= 8'd0;
    end else if (w_cap_drop) begin
      r_beat_cnt <= in_len_i;
    end else if (w_err_valid && bus.s_r_ready_i && !w_last) begin
      r_beat_cnt <= r_beat_cnt - 8'd1;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_drop_cnt <= '0;
      r_miss_cnt <= '0;
    end else if (w_cap_drop) begin
      if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end
      if (miss_i && (r_miss_cnt != {CNT_WIDTH{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + CNT_ONE;
      end
    end
  end

  assign w_err_valid         = (r_state == S_ERR);
  assign bus.m_ar_valid_o    = (r_state == S_ADDR);
  assign bus.m_ar_addr_o     = r_addr;
  assign bus.m_ar_id_o       = r_id;
  assign bus.m_ar_len_o      = r_len;
  assign bus.m_ar_user_o     = r_user;
  assign bus.m_ar_coherent_o = r_coh;
  assign bus.s_r_valid_o     = w_err_valid;
  assign bus.s_r_id_o        = r_id;
  assign bus.s_r_data_o      = '0;
  assign bus.s_r_resp_o      = w_err_valid ? 2'b10 : 2'b00;
  assign bus.s_r_last_o      = w_err_valid && w_last;
  assign err_busy_o          = w_err_valid;
  assign drop_cnt_o          = r_drop_cnt;
  assign miss_cnt_o          = r_miss_cnt;

endmodule

// File: tb/tb_rab_ar_sender.sv
// Directed plus randomized bench for rab_ar_sender; expected responses come from a
// per-request transaction model (beat lists, latency, saturating statistics).
module tb_rab_ar_sender;
  localparam int CW = 5;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          accept_i = 1'b0, drop_i = 1'b0, miss_i = 1'b0, coh_i = 1'b0;
  logic [39:0]   out_addr_i = 40'd0;
  logic [7:0]    id_i = 8'd0, len_i = 8'd0;
  logic [5:0]    user_i = 6'd0;
  logic          sent_o, err_busy_o;
  logic [CW-1:0] drop_cnt_o, miss_cnt_o;
  int            n_vec = 0, n_err = 0;
  logic [CW-1:0] exp_drop = '0, exp_miss = '0;

  rab_ar_sender_if #(.AXI_M_ADDR_WIDTH(40), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(6),
                     .AXI_DATA_WIDTH(64)) bus ();

  rab_ar_sender #(.AXI_M_ADDR_WIDTH(40), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(6),
                  .AXI_DATA_WIDTH(64), .CNT_WIDTH(CW)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .accept_i(accept_i), .drop_i(drop_i), .miss_i(miss_i),
    .out_addr_i(out_addr_i), .cache_coherent_i(coh_i), .in_id_i(id_i), .in_len_i(len_i),
    .in_user_i(user_i), .sent_o(sent_o), .bus(bus), .err_busy_o(err_busy_o),
    .drop_cnt_o(drop_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
    check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    check("miss_cnt", 64'(miss_cnt_o), 64'(exp_miss));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      accept_i = 1'b0; drop_i = 1'b0;
      #1;
      check("idle_ar_valid", 64'(bus.m_ar_valid_o), 64'd0);
      check("idle_r_valid", 64'(bus.s_r_valid_o), 64'd0);
      check("idle_sent", 64'(sent_o), 64'd0);
    end
  endtask

  // Accepted read: AR appears the cycle after capture and holds for stall+1 cycles.
  task automatic do_accept(input logic [39:0] a, input logic [7:0] id, input logic [7:0] len,
                           input logic [5:0] u, input logic coh, input int stall);
    @(negedge clk);
    drop_i = 1'b0; miss_i = 1'b0; accept_i = 1'b1;
    out_addr_i = a; id_i = id; len_i = len; user_i = u; coh_i = coh;
    bus.m_ar_ready_i = (stall == 0); bus.s_r_ready_i = 1'b1;
    #1;
    check("acc_capture_valid", 64'(bus.m_ar_valid_o), 64'd0);
    check("acc_capture_sent", 64'(sent_o), 64'd0);
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      bus.m_ar_ready_i = (c == stall);
      #1;
      check("ar_valid", 64'(bus.m_ar_valid_o), 64'd1);
      check("ar_addr", 64'(bus.m_ar_addr_o), 64'(a));
      check("ar_id", 64'(bus.m_ar_id_o), 64'(id));
      check("ar_len", 64'(bus.m_ar_len_o), 64'(len));
      check("ar_user", 64'(bus.m_ar_user_o), 64'(u));
      check("ar_coh", 64'(bus.m_ar_coherent_o), 64'(coh));
      check("ar_sent", 64'(sent_o), 64'(c == stall));
      check("ar_err_busy", 64'(err_busy_o), 64'd0);
    end
    check_stats();
  endtask

  // Dropped read: len+1 SLVERR beats; mode 0 ready high, 1 toggling, 2 random.
  task automatic do_drop(input logic [7:0] id, input logic [7:0] len, input logic miss,
                         input int mode, input int abort_at);
    int b = 0;
    int c = 0;
    @(negedge clk);
    accept_i = 1'b0; drop_i = 1'b1; miss_i = miss; id_i = id; len_i = len;
    out_addr_i = 40'd0; bus.s_r_ready_i = 1'b0;
    #1;
    check("drop_capture_valid", 64'(bus.s_r_valid_o), 64'd0);
    exp_drop = (exp_drop == CMAX) ? CMAX : exp_drop + 1'b1;
    if (miss) exp_miss = (exp_miss == CMAX) ? CMAX : exp_miss + 1'b1;
    while (b <= int'(len) && c < 1100) begin
      @(negedge clk);
      if (abort_at >= 0 && b == abort_at) break;
      case (mode)
        0:       bus.s_r_ready_i = 1'b1;
        1:       bus.s_r_ready_i = c[0];
        default: bus.s_r_ready_i = (c >= 4 * int'(len) + 8) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      #1;
      check("r_valid", 64'(bus.s_r_valid_o), 64'd1);
      check("r_busy", 64'(err_busy_o), 64'd1);
      check("r_id", 64'(bus.s_r_id_o), 64'(id));
      check("r_data", bus.s_r_data_o, 64'd0);
      check("r_resp", 64'(bus.s_r_resp_o), 64'd2);
      check("r_last", 64'(bus.s_r_last_o), 64'(b == int'(len)));
      check("r_sent", 64'(sent_o), 64'(bus.s_r_ready_i && b == int'(len)));
      check("r_ar_valid", 64'(bus.m_ar_valid_o), 64'd0);
      if (bus.s_r_ready_i) b++;
      c++;
    end
    if (abort_at < 0) begin
      check("drop_beats_done", 64'(b), 64'(int'(len) + 1));
      check_stats();
    end
  endtask

  initial begin
    logic [63:0] t;
    bus.m_ar_ready_i = 1'b0; bus.s_r_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ar_valid", 64'(bus.m_ar_valid_o), 64'd0);
    check("rst_r_valid", 64'(bus.s_r_valid_o), 64'd0);
    check("rst_sent", 64'(sent_o), 64'd0);
    check("rst_ar_addr", 64'(bus.m_ar_addr_o), 64'd0);
    check("rst_resp", 64'(bus.s_r_resp_o), 64'd0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    do_accept(40'h12_3456_7000, 8'd5, 8'd3, 6'h2a, 1'b1, 0);
    idle(1);
    do_accept(40'hab_cdef_0123, 8'd77, 8'd15, 6'h11, 1'b0, 4);
    idle(1);
    do_drop(8'd9, 8'd2, 1'b1, 0, -1);
    idle(1);
    do_drop(8'd3, 8'd0, 1'b0, 1, -1);
    do_drop(8'd4, 8'd7, 1'b0, 0, -1);
    do_accept(40'h00_0000_1000, 8'd8, 8'd1, 6'h01, 1'b0, 0);
    idle(1);
    do_drop(8'hfe, 8'd255, 1'b1, 0, -1);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_drop(8'($urandom), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2, -1);
      end else begin
        t = {$urandom(), $urandom()};
        do_accept(t[39:0], 8'($urandom), 8'($urandom), 6'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    do_drop(8'd6, 8'd7, 1'b1, 0, 2);
    rst_n = 1'b0;
    #1;
    check("arst_r_valid", 64'(bus.s_r_valid_o), 64'd0);
    check("arst_busy", 64'(err_busy_o), 64'd0);
    check("arst_last", 64'(bus.s_r_last_o), 64'd0);
    check("arst_sent", 64'(sent_o), 64'd0);
    check("arst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("arst_miss_cnt", 64'(miss_cnt_o), 64'd0);
    drop_i = 1'b0;
    exp_drop = '0; exp_miss = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_stats();

    for (int i = 0; i < (1 << CW) + 3; i++) begin
      do_drop(8'(i), 8'd0, 1'b1, 0, -1);
    end
    idle(1);
    check("sat_drop_cnt", 64'(drop_cnt_o), 64'(CMAX));
    check("sat_miss_cnt", 64'(miss_cnt_o), 64'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
